// File: rtl/traffic_light_monitor_pkg.sv
// rtl/traffic_light_monitor_pkg.sv - shared encodings for the traffic light monitor
package traffic_light_monitor_pkg;

  typedef enum logic [1:0] {
    PH_NONE   = 2'd0,
    PH_RED    = 2'd1,
    PH_YELLOW = 2'd2,
    PH_GREEN  = 2'd3
  } phase_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_TRK_RED    = 3'd1,
    ST_TRK_YELLOW = 3'd2,
    ST_TRK_GREEN  = 3'd3,
    ST_FAULT      = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    LAMP_DARK    = 3'd0,
    LAMP_RED     = 3'd1,
    LAMP_YELLOW  = 3'd2,
    LAMP_GREEN   = 3'd3,
    LAMP_ILLEGAL = 3'd4
  } lamp_t;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_ILLEGAL  = 3'd1;
  localparam logic [2:0] FC_DARK     = 3'd2;
  localparam logic [2:0] FC_SEQUENCE = 3'd3;
  localparam logic [2:0] FC_SHORT    = 3'd4;
  localparam logic [2:0] FC_LONG     = 3'd5;

  // Lamp vector is {red, yellow, green}; more than one lit is illegal.
  function automatic lamp_t decode_lamps(input logic [2:0] v);
    case (v)
      3'b000:  return LAMP_DARK;
      3'b100:  return LAMP_RED;
      3'b010:  return LAMP_YELLOW;
      3'b001:  return LAMP_GREEN;
      default: return LAMP_ILLEGAL;
    endcase
  endfunction

  function automatic phase_t state_to_phase(input state_t s);
    case (s)
      ST_TRK_RED:    return PH_RED;
      ST_TRK_YELLOW: return PH_YELLOW;
      ST_TRK_GREEN:  return PH_GREEN;
      default:       return PH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_monitor_ms_tick_gen.sv
// rtl/traffic_light_monitor_ms_tick_gen.sv - 1 ms prescaler with synchronous restart
module ms_tick_gen #(
  parameter int DIV = 27_000
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic restart,
  output logic ms_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign ms_tick = (cnt == LAST);

  // Count DIV cycles per tick; restart realigns the ms grid to a phase entry.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || ms_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - checks traffic light phase order and durations
module traffic_light_monitor
  import traffic_light_monitor_pkg::*;
#(
  parameter int CLK_FREQUENCY = 27_000_000,
  parameter int RED_MS        = 10000,
  parameter int YELLOW_MS     = 3000,
  parameter int GREEN_MS      = 7000,
  parameter int TOL_MS        = 2
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        red,
  input  logic        yellow,
  input  logic        green,
  input  logic        clear_fault,
  output logic [1:0]  phase,
  output logic        phase_done,
  output logic [15:0] last_ms,
  output logic [15:0] cycle_count,
  output logic        fault,
  output logic [2:0]  fault_code
);

  logic [2:0]  sync1, sync2;
  state_t      state, state_n;
  lamp_t       lamp, cur_lamp, nxt_lamp;
  state_t      nxt_state;
  int          min_ms, max_ms;
  logic [15:0] ms, eff_ms;
  logic [2:0]  code_n;
  logic        done_n, inc_cycle, restart, ms_tick;

  ms_tick_gen #(.DIV(CLK_FREQUENCY / 1000)) u_tick (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .restart (restart),
    .ms_tick (ms_tick)
  );

  // Two-flop synchronizer on the asynchronous lamp drives.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {red, yellow, green};
      sync2 <= sync1;
    end
  end

  // Next state, fault cause and measurement; eff_ms counts a tick landing on this edge.
  always_comb begin
    lamp      = decode_lamps(sync2);
    eff_ms    = (ms_tick && (ms != 16'hFFFF)) ? ms + 16'd1 : ms;
    cur_lamp  = LAMP_DARK;
    nxt_lamp  = LAMP_DARK;
    nxt_state = ST_IDLE;
    min_ms    = 0;
    max_ms    = 0;
    case (state)
      ST_TRK_RED: begin
        cur_lamp = LAMP_RED;    nxt_lamp = LAMP_YELLOW; nxt_state = ST_TRK_YELLOW;
        min_ms = RED_MS - TOL_MS;    max_ms = RED_MS + TOL_MS + 1;
      end
      ST_TRK_YELLOW: begin
        cur_lamp = LAMP_YELLOW; nxt_lamp = LAMP_GREEN;  nxt_state = ST_TRK_GREEN;
        min_ms = YELLOW_MS - TOL_MS; max_ms = YELLOW_MS + TOL_MS + 1;
      end
      ST_TRK_GREEN: begin
        cur_lamp = LAMP_GREEN;  nxt_lamp = LAMP_RED;    nxt_state = ST_TRK_RED;
        min_ms = GREEN_MS - TOL_MS;  max_ms = GREEN_MS + TOL_MS + 1;
      end
      default: ;
    endcase

    state_n   = state;
    code_n    = fault_code;
    done_n    = 1'b0;
    inc_cycle = 1'b0;
    case (state)
      ST_IDLE: begin
        if (lamp == LAMP_ILLEGAL) begin
          state_n = ST_FAULT; code_n = FC_ILLEGAL;
        end else if (lamp == LAMP_RED) begin
          state_n = ST_TRK_RED;
        end
      end
      ST_TRK_RED, ST_TRK_YELLOW, ST_TRK_GREEN: begin
        if (lamp == LAMP_ILLEGAL) begin
          state_n = ST_FAULT; code_n = FC_ILLEGAL;
        end else if (lamp == LAMP_DARK) begin
          state_n = ST_FAULT; code_n = FC_DARK;
        end else if (lamp == cur_lamp) begin
          if (int'(eff_ms) >= max_ms) begin
            state_n = ST_FAULT; code_n = FC_LONG;
          end
        end else if (lamp == nxt_lamp) begin
          if (int'(eff_ms) < min_ms) begin
            state_n = ST_FAULT; code_n = FC_SHORT;
          end else if (int'(eff_ms) >= max_ms) begin
            state_n = ST_FAULT; code_n = FC_LONG;
          end else begin
            state_n   = nxt_state;
            done_n    = 1'b1;
            inc_cycle = (state == ST_TRK_GREEN);
          end
        end else begin
          state_n = ST_FAULT; code_n = FC_SEQUENCE;
        end
      end
      ST_FAULT: begin
        if (clear_fault) begin
          state_n = ST_IDLE; code_n = FC_NONE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    restart = (state_n != state) || (state_n == ST_IDLE) || (state_n == ST_FAULT);
  end

  // State, phase timer and registered outputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ms          <= '0;
      phase       <= '0;
      phase_done  <= 1'b0;
      last_ms     <= '0;
      cycle_count <= '0;
      fault       <= 1'b0;
      fault_code  <= '0;
    end else begin
      state      <= state_n;
      ms         <= restart ? 16'd0 : eff_ms;
      phase      <= state_to_phase(state_n);
      phase_done <= done_n;
      if (done_n)    last_ms     <= eff_ms;
      if (inc_cycle) cycle_count <= cycle_count + 16'd1;
      fault      <= (state_n == ST_FAULT);
      fault_code <= code_n;
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - directed self-checking bench for traffic_light_monitor
module tb_traffic_light_monitor;

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b001;

  logic        sys_clk = 1'b0;
  logic        rst_n, red, yellow, green, clear_fault;
  logic [1:0]  phase;
  logic        phase_done;
  logic [15:0] last_ms, cycle_count;
  logic        fault;
  logic [2:0]  fault_code;

  int n_pass  = 0;
  int n_total = 0;

  always #5 sys_clk = ~sys_clk;

  traffic_light_monitor #(
    .CLK_FREQUENCY (10_000),
    .RED_MS        (10),
    .YELLOW_MS     (3),
    .GREEN_MS      (7),
    .TOL_MS        (1)
  ) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .red         (red),
    .yellow      (yellow),
    .green       (green),
    .clear_fault (clear_fault),
    .phase       (phase),
    .phase_done  (phase_done),
    .last_ms     (last_ms),
    .cycle_count (cycle_count),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic lamps(input logic [2:0] v);
    {red, yellow, green} = v;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    clear_fault = 1'b0;
    lamps(3'b000);
    step(3);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clear_fault = 1'b0;
    lamps(3'b000);
    #1;
    n_total++;
    if ({phase, phase_done, last_ms, cycle_count, fault, fault_code} !== 39'd0)
      $display("FAIL reset_outputs actual=%h required=0",
               {phase, phase_done, last_ms, cycle_count, fault, fault_code});
    else n_pass++;
    step(3);
    rst_n = 1'b1;
    step(5);
    n_total++;
    if (phase !== 2'd0 || fault !== 1'b0)
      $display("FAIL reset_idle_dark actual=phase%0d/fault%0b required=phase0/fault0", phase, fault);
    else n_pass++;
  endtask

  task automatic test_nominal;
    logic [2:0]  seq[7]    = '{L_R, L_Y, L_G, L_R, L_Y, L_G, L_R};
    int          hold[7]   = '{100, 30, 70, 100, 30, 70, 0};
    logic [15:0] exp_ms[7] = '{16'd0, 16'd10, 16'd3, 16'd7, 16'd10, 16'd3, 16'd7};
    logic [1:0]  exp_ph[7] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1};
    do_reset();
    lamps(seq[0]);
    step(3);
    n_total++;
    if (phase !== 2'd1)
      $display("FAIL nominal_first_red phase actual=%0d required=1", phase);
    else n_pass++;
    step(hold[0] - 3);
    for (int i = 1; i < 7; i++) begin
      lamps(seq[i]);
      step(2);
      n_total++;
      if (phase_done !== 1'b0)
        $display("FAIL nominal_early_done[%0d] actual=%0b required=0", i, phase_done);
      else n_pass++;
      step(1);
      n_total++;
      if (phase_done !== 1'b1 || last_ms !== exp_ms[i] || phase !== exp_ph[i])
        $display("FAIL nominal_done[%0d] actual=done%0b/ms%0d/ph%0d required=done1/ms%0d/ph%0d",
                 i, phase_done, last_ms, phase, exp_ms[i], exp_ph[i]);
      else n_pass++;
      if (i < 6) step(hold[i] - 3);
    end
    step(1);
    n_total++;
    if (phase_done !== 1'b0)
      $display("FAIL nominal_pulse_width actual=%0b required=0", phase_done);
    else n_pass++;
    n_total++;
    if (cycle_count !== 16'd2 || fault !== 1'b0)
      $display("FAIL nominal_cycles actual=cnt%0d/fault%0b required=cnt2/fault0", cycle_count, fault);
    else n_pass++;
  endtask

  task automatic test_long;
    do_reset();
    lamps(L_R);
    step(122);
    n_total++;
    if (fault !== 1'b0)
      $display("FAIL long_early actual=%0b required=0", fault);
    else n_pass++;
    step(1);
    n_total++;
    if (fault !== 1'b1 || fault_code !== 3'd5 || phase !== 2'd0)
      $display("FAIL long_fault actual=f%0b/c%0d/ph%0d required=f1/c5/ph0", fault, fault_code, phase);
    else n_pass++;
  endtask

  task automatic test_short_clear;
    do_reset();
    lamps(L_R);
    step(100);
    lamps(L_Y);
    step(10);
    lamps(L_G);
    step(2);
    n_total++;
    if (fault !== 1'b0)
      $display("FAIL short_early actual=%0b required=0", fault);
    else n_pass++;
    step(1);
    n_total++;
    if (fault !== 1'b1 || fault_code !== 3'd4)
      $display("FAIL short_fault actual=f%0b/c%0d required=f1/c4", fault, fault_code);
    else n_pass++;
    step(5);
    n_total++;
    if (fault_code !== 3'd4 || phase !== 2'd0)
      $display("FAIL short_held actual=c%0d/ph%0d required=c4/ph0", fault_code, phase);
    else n_pass++;
    clear_fault = 1'b1;
    step(1);
    clear_fault = 1'b0;
    n_total++;
    if (fault !== 1'b0 || fault_code !== 3'd0 || phase !== 2'd0)
      $display("FAIL clear_fault actual=f%0b/c%0d/ph%0d required=f0/c0/ph0", fault, fault_code, phase);
    else n_pass++;
    lamps(L_R);
    step(3);
    clear_fault = 1'b1;
    step(1);
    clear_fault = 1'b0;
    n_total++;
    if (phase !== 2'd1 || fault !== 1'b0)
      $display("FAIL clear_outside_fault actual=ph%0d/f%0b required=ph1/f0", phase, fault);
    else n_pass++;
  endtask

  task automatic test_illegal_sequence;
    do_reset();
    lamps(L_R);
    step(50);
    lamps(L_R | L_G);
    step(3);
    n_total++;
    if (fault !== 1'b1 || fault_code !== 3'd1)
      $display("FAIL illegal_code actual=f%0b/c%0d required=f1/c1", fault, fault_code);
    else n_pass++;
    do_reset();
    lamps(L_R);
    step(100);
    lamps(L_G);
    step(3);
    n_total++;
    if (fault !== 1'b1 || fault_code !== 3'd3)
      $display("FAIL sequence_code actual=f%0b/c%0d required=f1/c3", fault, fault_code);
    else n_pass++;
  endtask

  task automatic test_reset_mid_phase;
    do_reset();
    lamps(L_R);
    step(100);
    lamps(L_Y);
    step(15);
    n_total++;
    if (last_ms !== 16'd10 || phase !== 2'd2)
      $display("FAIL midreset_pre actual=ms%0d/ph%0d required=ms10/ph2", last_ms, phase);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({phase, phase_done, last_ms, cycle_count, fault, fault_code} !== 39'd0)
      $display("FAIL midreset_outputs actual=%h required=0",
               {phase, phase_done, last_ms, cycle_count, fault, fault_code});
    else n_pass++;
    @(negedge sys_clk);
    rst_n = 1'b1;
    step(10);
    n_total++;
    if (phase !== 2'd0 || fault !== 1'b0)
      $display("FAIL midreset_yellow_ignored actual=ph%0d/f%0b required=ph0/f0", phase, fault);
    else n_pass++;
    lamps(L_R);
    step(3);
    n_total++;
    if (phase !== 2'd1 || fault !== 1'b0)
      $display("FAIL midreset_red_accept actual=ph%0d/f%0b required=ph1/f0", phase, fault);
    else n_pass++;
    step(92);
    lamps(L_Y);
    step(3);
    n_total++;
    if (phase_done !== 1'b1 || last_ms !== 16'd9 || fault !== 1'b0)
      $display("FAIL midreset_last_ms actual=d%0b/ms%0d/f%0b required=d1/ms9/f0", phase_done, last_ms, fault);
    else n_pass++;
  endtask

  task automatic test_cycle_wrap;
    do_reset();
    force dut.cycle_count = 16'hFFFF;
    #1;
    release dut.cycle_count;
    #1;
    n_total++;
    if (cycle_count !== 16'hFFFF)
      $display("FAIL wrap_preload actual=%h required=ffff", cycle_count);
    else n_pass++;
    lamps(L_R);
    step(100);
    lamps(L_Y);
    step(30);
    lamps(L_G);
    step(70);
    lamps(L_R);
    step(3);
    n_total++;
    if (cycle_count !== 16'd0 || phase_done !== 1'b1 || last_ms !== 16'd7)
      $display("FAIL wrap_count actual=cnt%h/d%0b/ms%0d required=cnt0000/d1/ms7", cycle_count, phase_done, last_ms);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_long();
    test_short_clear();
    test_illegal_sequence();
    test_reset_mid_phase();
    test_cycle_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameters, one per line: name, default, meaning. CLK_FREQUENCY, 27_000_000, sys_clk frequency in Hz.
REQ-002 RED_MS, 10000, nominal red duration; YELLOW_MS, 3000, nominal yellow duration; GREEN_MS, 7000, nominal green duration; TOL_MS, 2, allowed deviation in ms.
REQ-003 Ports, one per line: name, direction, width, meaning. sys_clk, in, 1, clock.
REQ-004 rst_n, in, 1, reset; asynchronous, active-low.
REQ-005 red / yellow / green, in, 1 each, observed lamp drives; asynchronous to sys_clk.
REQ-006 clear_fault, in, 1, synchronous request to leave FAULT.
REQ-007 phase, out, 2, current tracked phase: 0 NONE, 1 RED, 2 YELLOW, 3 GREEN.
REQ-008 phase_done, out, 1, one-cycle pulse on each legal phase transition.
REQ-009 last_ms, out, 16, measured duration of the phase that just ended.
REQ-010 cycle_count, out, 16, count of completed GREEN->RED transitions.
REQ-011 fault, out, 1, sticky fault flag; fault_code, out, 3, cause of the fault.

Function
REQ-012 Each lamp input SHALL pass a 2-flop synchronizer; decode and FSM use synchronized values only.
REQ-013 Decode: 100 RED, 010 YELLOW, 001 GREEN, 000 DARK; any vector with two or more lamps lit is ILLEGAL.
REQ-014 FSM states: IDLE, TRK_RED, TRK_YELLOW, TRK_GREEN, FAULT.
REQ-015 IDLE: DARK, YELLOW and GREEN are ignored; RED goes to TRK_RED without a duration check; ILLEGAL goes to FAULT.
REQ-016 Legal transitions: TRK_RED->TRK_YELLOW, TRK_YELLOW->TRK_GREEN, TRK_GREEN->TRK_RED.
REQ-017 Any other lamp change while tracking goes to FAULT with code SEQUENCE.
REQ-018 A 1 ms prescaler SHALL count CLK_FREQUENCY/1000 cycles and emit ms_tick; on every phase entry it restarts at 0 together with the phase ms counter.
REQ-019 The phase ms counter SHALL be 16 bits, increment on ms_tick, and saturate at 0xFFFF.
REQ-020 On a legal transition: if ms < NOM-TOL, go to FAULT with code SHORT; otherwise pulse phase_done, load last_ms from ms, and enter the next phase.
REQ-021 While tracking, when ms reaches NOM+TOL+1, go to FAULT with code LONG without waiting for a lamp change.
REQ-022 DARK while tracking goes to FAULT with code DARK.
REQ-023 Fault codes: 1 ILLEGAL, 2 DARK, 3 SEQUENCE, 4 SHORT, 5 LONG. Simultaneous causes are resolved by priority in that order, highest first.
REQ-024 cycle_count SHALL increment on each legal GREEN->RED transition and wrap 0xFFFF->0.
REQ-025 Latency: a lamp pin change SHALL produce its phase_done or fault response exactly 3 sys_clk cycles later (2 synchronizer cycles plus 1 register).
REQ-026 FAULT: phase=0, fault=1, and fault_code is held.
REQ-027 In FAULT, clear_fault=1 moves the FSM to IDLE next cycle and clears fault and fault_code. clear_fault outside FAULT has no effect.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 rst_n low SHALL asynchronously clear synchronizers, prescaler, ms counter, FSM (to IDLE), phase, phase_done, last_ms, cycle_count, fault and fault_code to 0.
REQ-030 Reset asserted mid-phase SHALL discard the partial measurement. After release, the first RED is accepted without a duration check.

Structure
REQ-031 A shared package SHALL hold the phase encoding, FSM state enum, and fault code constants.
REQ-032 The prescaler SHALL be a sub-module ms_tick_gen with inputs sys_clk, rst_n, restart and output ms_tick.

Verification
Bench parameters: CLK_FREQUENCY=10_000, RED_MS=10, YELLOW_MS=3, GREEN_MS=7, TOL_MS=1.
REQ-033 Nominal sequence red 100, yellow 30, green 70 cycles, repeated twice -> phase_done after each phase with last_ms 10/3/7, cycle_count=2, fault=0.
REQ-034 Red held 120 cycles -> fault_code=5 (LONG) when ms reaches 12, 3 cycles after that tick.
REQ-035 Yellow of 10 cycles -> fault_code=4 (SHORT) at the green edge+3; clear_fault -> IDLE, fault=0.
REQ-036 Red and green asserted together during red -> fault_code=1 (ILLEGAL), not SEQUENCE. Red directly to green -> fault_code=3 (SEQUENCE).
REQ-037 rst_n pulsed mid-yellow -> all outputs 0; next red accepted with no fault, and last_ms reflects only post-reset phases.
REQ-038 cycle_count preloaded to 0xFFFF via forced state, then one GREEN->RED -> cycle_count=0.
